// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction prefetcher feeding IF/ID through a DEPTH-entry FIFO.
// Ports: clk/rst (async, active-low); redirect/redirect_pc flush and retarget fetch;
// stall holds the head; imem_req/imem_addr/imem_gnt issue word fetches;
// imem_rvalid/imem_rdata return words in issue order; if_valid/if_pc/if_inst present the head.
// Optional FETCH_QUEUE_BYPASS_EN forwards a response straight to if_* when the queue is empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] NOP_INST = 32'h13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  logic [CW-1:0] count, inflight, discard;
  logic [AW-1:0] wptr, rptr;
  logic [31:0]   fetch_pc, resp_pc;
  logic [31:0]   pc_mem [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [CW:0]   credit;
  logic          issue, take, push, pop;
  // Requests are only issued while every outstanding response has a guaranteed slot.
  assign credit    = {1'b0, count} + {1'b0, inflight};
  assign imem_req  = rst && !redirect && credit < (CW+1)'(DEPTH);
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_gnt;
  assign take      = imem_rvalid && !redirect && discard == '0;
  assign pop       = count != '0 && !stall && !redirect;
`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp;
  assign byp      = take && count == '0;
  // A bypassed word consumed this cycle never enters the FIFO.
  assign push     = take && !(byp && !stall);
  assign if_valid = count != '0 || byp;
  assign if_pc    = count != '0 ? pc_mem[rptr] : byp ? resp_pc : '0;
  assign if_inst  = count != '0 ? inst_mem[rptr] : byp ? imem_rdata : NOP_INST;
`else
  assign push     = take;
  assign if_valid = count != '0;
  assign if_pc    = if_valid ? pc_mem[rptr] : '0;
  assign if_inst  = if_valid ? inst_mem[rptr] : NOP_INST;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      inflight <= inflight + CW'(issue) - CW'(imem_rvalid);
      if (redirect) begin
        // Everything still pending after this cycle belongs to the old path.
        count    <= '0;
        wptr     <= '0;
        rptr     <= '0;
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        resp_pc  <= redirect_pc & 32'hFFFF_FFFC;
        discard  <= inflight - CW'(imem_rvalid);
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (imem_rvalid && discard != '0) discard <= discard - 1'b1;
        if (take) resp_pc <= resp_pc + 32'd4;
        if (push) wptr <= wptr + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  always_ff @(posedge clk)
    if (push) begin
      pc_mem[wptr]   <= resp_pc;
      inst_mem[wptr] <= imem_rdata;
    end
endmodule
